// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous line, plus one-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi, receives MSB-first words, returns a buffered tx word.
//   state  | meaning
//   IDLE   | cs_n high, miso held low, waiting for cs_n fall
//   ACTIVE | frame in progress, shifting on synchronised sclk edges
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_full;
  logic              pend_load;
  logic              pend_full;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic              mosi_s;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign tx_ready = !tx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      pend_load   <= 1'b0;
      pend_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state     <= ACTIVE;
            bit_cnt   <= '0;
            pend_load <= 1'b0;
            tx_sh     <= tx_full ? tx_buf : '0;
            miso      <= tx_full & tx_buf[DATA_W-1];
            if (tx_full) tx_full     <= 1'b0;
            else         tx_underrun <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            pend_load <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
            end else if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              // Next-word buffer bookkeeping is committed only once the master
              // actually clocks the word, so a trailing fall costs nothing.
              if (pend_load) begin
                pend_load <= 1'b0;
                if (pend_full) tx_full     <= 1'b0;
                else           tx_underrun <= 1'b1;
              end
            end else if (bit_cnt == CNT_FULL) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end
            if (sclk_fall) begin
              if (bit_cnt == '0 || bit_cnt == CNT_FULL) begin
                tx_sh     <= tx_full ? tx_buf : '0;
                miso      <= tx_full & tx_buf[DATA_W-1];
                pend_load <= 1'b1;
                pend_full <= tx_full;
              end else begin
                tx_sh <= tx_sh << 1;
                miso  <= tx_sh[DATA_W-2];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
